// File: rtl/array_multiplier8_aor_lock32.sv
// Logic-locked 8x8 unsigned array multiplier with AND/OR key gates.
// ARRAY_MULT_IN_REG_EN adds an input register stage (latency 2).
module array_multiplier8_aor_lock32 #(
  parameter logic [31:0] CORRECT_KEY = 32'hF6301537
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  operand1_i,
  input  logic [7:0]  operand2_i,
  input  logic [31:0] keyinput,
  output logic [15:0] result_o
);

  logic [7:0]       a_s;
  logic [7:0]       b_s;
  logic [31:0]      k_s;
  logic [7:0][7:0]  gp;
  logic [15:0]      sum;

`ifdef ARRAY_MULT_IN_REG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_s <= '0;
      b_s <= '0;
      k_s <= '0;
    end else begin
      a_s <= operand1_i;
      b_s <= operand2_i;
      k_s <= keyinput;
    end
  end
`else
  assign a_s = operand1_i;
  assign b_s = operand2_i;
  assign k_s = keyinput;
`endif

  // Key bit k gates pp(k/4, 2*(k%4) + (k/4)%2): a checkerboard.
  always_comb begin
    gp = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        gp[r][c] = a_s[c] & b_s[r];
    for (int k = 0; k < 32; k++) begin
      if (CORRECT_KEY[k])
        gp[k/4][2*(k%4)+(k/4)%2] = gp[k/4][2*(k%4)+(k/4)%2] & k_s[k];
      else
        gp[k/4][2*(k%4)+(k/4)%2] = gp[k/4][2*(k%4)+(k/4)%2] | k_s[k];
    end
  end

  // Ripple-carry array: each row adds into the running sum bit by bit.
  always_comb begin
    logic [15:0] row;
    logic        cy;
    logic        s;
    sum = '0;
    row = '0;
    cy  = 1'b0;
    s   = 1'b0;
    for (int r = 0; r < 8; r++) begin
      row = {8'h00, gp[r]} << r;
      cy  = 1'b0;
      for (int i = 0; i < 16; i++) begin
        s      = sum[i] ^ row[i] ^ cy;
        cy     = (sum[i] & row[i]) | (cy & (sum[i] ^ row[i]));
        sum[i] = s;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      result_o <= 16'h0000;
    else
      result_o <= sum;
  end

endmodule

// File: tb/tb_array_multiplier8_aor_lock32.sv
// Bench for array_multiplier8_aor_lock32: directed vectors, random keys,
// exhaustive correct-key sweep against an arithmetic reference model.
module tb_array_multiplier8_aor_lock32;

`ifdef ARRAY_MULT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [31:0] KEY = 32'hF6301537;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  operand1_i;
  logic [7:0]  operand2_i;
  logic [31:0] keyinput;
  logic [15:0] result_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  array_multiplier8_aor_lock32 dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .operand1_i(operand1_i),
    .operand2_i(operand2_i),
    .keyinput(keyinput),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Locked pps sit where row and column parity match; key bit
  // index is row*4 + col/2. Wrong AND bit kills pp, wrong OR bit forces it.
  function automatic logic [15:0] ref_mul(input logic [7:0] a,
      input logic [7:0] b, input logic [31:0] key);
    int total = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int p = int'(a[c] & b[r]);
        if ((r % 2) == (c % 2)) begin
          int k = r * 4 + c / 2;
          if (KEY[k]) p = p & int'(key[k]);
          else        p = p | int'(key[k]);
        end
        total += p * (1 << (r + c));
      end
    return total[15:0];
  endfunction

  task automatic tick(input logic [7:0] a, input logic [7:0] b,
                      input logic [31:0] key, input logic rst);
    operand1_i = a;
    operand2_i = b;
    keyinput   = key;
    rst_i      = rst;
    exp_q.push_back(rst ? 16'h0000 : ref_mul(a, b, key));
    @(posedge clk_i);
    #1;
    if (exp_q.size() >= LAT) check("pipe", result_o, exp_q.pop_front());
  endtask

  task automatic hold(input logic [7:0] a, input logic [7:0] b,
                      input logic [31:0] key, input logic [15:0] exp,
                      input string tag);
    repeat (LAT) tick(a, b, key, 1'b0);
    check(tag, result_o, exp);
  endtask

  initial begin
    rst_i = 1'b1;
    operand1_i = 8'hFF;
    operand2_i = 8'hFF;
    keyinput = KEY;
    tick(8'hFF, 8'hFF, KEY, 1'b1);
    tick(8'hFF, 8'hFF, KEY, 1'b1);
    check("reset", result_o, 16'h0000);
    tick(8'hFF, 8'hFF, KEY, 1'b0);
    if (LAT == 2) begin
      check("rel_zero", result_o, 16'h0000);
      tick(8'hFF, 8'hFF, KEY, 1'b0);
    end
    check("rel_ffff", result_o, 16'hFE01);

    hold(8'h29, 8'h7A, KEY, 16'h138A, "ok_29_7a");
    hold(8'h89, 8'hFF, KEY, 16'h8877, "ok_89_ff");
    hold(8'h80, 8'h80, KEY, 16'h4000, "ok_80_80");
    hold(8'h00, 8'h01, KEY, 16'h0000, "ok_00_01");
    hold(8'hFF, 8'hFF, 32'hF6301527, 16'hFDFD, "and_ffff");
    hold(8'h29, 8'h7A, 32'hF6301527, 16'h138A, "and_297a");
    hold(8'h00, 8'h00, 32'hF6311537, 16'h0010, "or_0000");
    hold(8'h11, 8'h11, 32'hF6311537, 16'h0121, "or_1111");

    for (int i = 0; i < 8; i++) begin
      tick(8'hFF, 8'hFF, (i % 2 == 0) ? KEY : 32'hF6301527, 1'b0);
      if (i >= LAT - 1)
        check("keysw", result_o,
              ((i - (LAT - 1)) % 2 == 0) ? 16'hFE01 : 16'hFDFD);
    end

    for (int i = 0; i < 300; i++)
      tick(8'($urandom), 8'($urandom), $urandom, 1'b0);

    tick(8'h55, 8'hAA, KEY, 1'b1);
    tick(8'h55, 8'hAA, KEY, 1'b1);
    check("mid_reset", result_o, 16'h0000);

    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        tick(8'(a), 8'(b), KEY, 1'b0);
    repeat (LAT) tick(8'h00, 8'h00, KEY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
